operand_streamer: RTL and testbench
===================================

OPERAND_STREAMER -- requirements
Module: operand_streamer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning width of one operand in bits.
REQ-002 SHALL have parameter NUM_OPS, default 2, meaning operands per beat (channel count), range 1..8.
REQ-003 SHALL have parameter DEPTH, default 1024, meaning beat buffer entries, power of two, minimum 2; AW = clog2(DEPTH).
REQ-004 SHALL have parameter SUM_W, default 32, meaning result checksum width.
REQ-005 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-006 reset_ni  input  1  reset, asynchronous assert, active-low.
REQ-007 ld_valid_i  input  1  load beat offered.
REQ-008 ld_data_i  input  NUM_OPS*DATA_W  load beat; operand k occupies bits [k*DATA_W +: DATA_W].
REQ-009 ld_ready_o  output  1  buffer accepts load beat.
REQ-010 clear_i  input  1  empty buffer, zero fill count, while IDLE.
REQ-011 start_i  input  1  begin streaming; sampled only in IDLE.
REQ-012 len_i  input  AW+1  beats to stream, sampled with start_i.
REQ-013 loop_i  input  1  wrap read pointer at fill count instead of ending early, sampled with start_i.
REQ-014 op_valid_o  output  1  operand beat valid.
REQ-015 op_data_o  output  NUM_OPS*DATA_W  operand beat, same packing as ld_data_i.
REQ-016 op_ready_i  input  1  downstream accepts beat.
REQ-017 res_valid_i  input  1  result word from downstream valid (no backpressure).
REQ-018 res_data_i  input  DATA_W  result word.
REQ-019 busy_o  output  1  high in STREAM or DRAIN.
REQ-020 done_o  output  1  one-cycle pulse on entering DONE.
REQ-021 fill_o  output  AW+1  beats held in buffer.
REQ-022 res_cnt_o  output  AW+1  results counted this run.
REQ-023 checksum_o  output  SUM_W  modulo-2^SUM_W sum of zero-extended res_data_i this run.

Function
REQ-024 SHALL implement states IDLE, STREAM, DRAIN, DONE; DONE returns to IDLE the next cycle.
REQ-025 Load: in IDLE, ld_ready_o = (fill_o < DEPTH); beat written at address fill_o, fill_o += 1 when ld_valid_i && ld_ready_o; ld_ready_o = 0 in all other states.
REQ-026 clear_i in IDLE SHALL zero fill_o next cycle and take priority over a same-cycle load; ignored outside IDLE.
REQ-027 IDLE->STREAM on start_i when len_i != 0 and fill_o != 0; start_i with len_i == 0 or fill_o == 0 SHALL go IDLE->DONE directly (done_o pulses, counters zeroed).
REQ-028 On start SHALL zero read pointer, beat counter, res_cnt_o and checksum_o; start_i and a load in the same cycle: the load SHALL complete and start SHALL be honoured, fill count including the new beat.
REQ-029 STREAM: op_data_o SHALL come from a registered buffer read; first op_valid_o asserts exactly 1 cycle after entering STREAM.
REQ-030 Handshake: beat transfers when op_valid_o && op_ready_i; while op_valid_o && !op_ready_i, op_data_o SHALL hold stable and op_valid_o SHALL stay high.
REQ-031 Back-to-back transfers SHALL sustain one beat per cycle with op_ready_i held high.
REQ-032 Read pointer after a transfer: if pointer == fill_o-1 then 0 when loop_i, else streaming ends; otherwise pointer+1.
REQ-033 Streaming SHALL end after len_i transfers, or (loop_i == 0) after fill_o transfers, whichever first; then STREAM->DRAIN, op_valid_o low.
REQ-034 Results SHALL be accumulated in any state except IDLE and DONE; res_cnt_o saturates at 2^(AW+1)-1; checksum wraps.
REQ-035 DRAIN->DONE when res_cnt_o equals beats transferred, including the case where equality already holds on entry.
REQ-036 res_cnt_o and checksum_o SHALL hold their final values through IDLE until the next start.

Reset
REQ-037 On reset_ni low, state SHALL be IDLE, ld_ready_o=1, op_valid_o=0, busy_o=0, done_o=0, fill_o=0, res_cnt_o=0, checksum_o=0; buffer contents need not be cleared.
REQ-038 Reset mid-STREAM or mid-DRAIN SHALL abort immediately to IDLE with no done_o pulse.

Verification
REQ-039 DATA_W=8, NUM_OPS=2: load beats {01,02},{03,04},{05,06}; start len=3 loop=0; op_ready_i=1; DUT echo res=A+B -> op beats in order one per cycle, res 03,07,0B, checksum 0x15, done_o one pulse.
REQ-040 Same load, len=7 loop=1 -> beat sequence 0,1,2,0,1,2,0; res_cnt_o=7 at done.
REQ-041 op_ready_i toggled 1,0,0,1 each cycle -> op_data_o stable across stalls, no beat dropped or duplicated.
REQ-042 Load DEPTH beats -> ld_ready_o falls after the DEPTH-th accept; extra ld_valid_i ignored; fill_o=DEPTH.
REQ-043 start with len=0 -> done_o pulse 1 cycle later, op_valid_o never asserts; clear_i -> fill_o=0.
REQ-044 reset_ni low during STREAM after 2 beats -> all outputs at reset values asynchronously, no done_o.

Source files
------------

// File: rtl/operand_streamer.sv
// operand_streamer: buffers operand beats loaded while idle, then streams them
// to a downstream unit (optionally wrapping) and accumulates a count and a
// checksum of the result words that come back.
module operand_streamer #(
  parameter  int DATA_W  = 8,
  parameter  int NUM_OPS = 2,
  parameter  int DEPTH   = 1024,
  parameter  int SUM_W   = 32,
  localparam int AW      = $clog2(DEPTH),
  localparam int BW      = NUM_OPS * DATA_W
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              ld_valid_i,
  input  logic [BW-1:0]     ld_data_i,
  output logic              ld_ready_o,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [AW:0]       len_i,
  input  logic              loop_i,
  output logic              op_valid_o,
  output logic [BW-1:0]     op_data_o,
  input  logic              op_ready_i,
  input  logic              res_valid_i,
  input  logic [DATA_W-1:0] res_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [AW:0]       fill_o,
  output logic [AW:0]       res_cnt_o,
  output logic [SUM_W-1:0]  checksum_o
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_e;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  state_e state_q, state_d;

  logic [BW-1:0]    mem [DEPTH];
  logic [AW:0]      fill_q;
  logic [AW:0]      total_q;
  logic [AW:0]      fetch_cnt_q;
  logic [AW:0]      xfer_cnt_q;
  logic [AW:0]      res_cnt_q;
  logic [AW-1:0]    rd_ptr_q;
  logic             op_valid_q;
  logic [BW-1:0]    op_data_q;
  logic [SUM_W-1:0] checksum_q;

  logic             idle;
  logic             load_acc;
  logic             start_go;
  logic             start_ok;
  logic [AW:0]      start_fill;
  logic [AW:0]      start_total;
  logic             xfer;
  logic             fetch;
  logic             last_xfer;
  logic             accum;

  // A start in the same cycle as a load sees the fill count including the new
  // beat; a same-cycle clear wins over the load and leaves nothing to stream.
  assign idle        = (state_q == IDLE);
  assign ld_ready_o  = idle && (fill_q < DEPTH_L);
  assign load_acc    = idle && ld_valid_i && ld_ready_o && !clear_i;
  assign start_go    = idle && start_i;
  assign start_fill  = clear_i ? '0 : (load_acc ? fill_q + ONE_L : fill_q);
  assign start_ok    = start_go && (len_i != '0) && (start_fill != '0);
  assign start_total = loop_i ? len_i : ((len_i < start_fill) ? len_i : start_fill);
  assign xfer        = op_valid_q && op_ready_i;
  assign fetch       = (state_q == STREAM) && (fetch_cnt_q != total_q) && (!op_valid_q || op_ready_i);
  assign last_xfer   = (state_q == STREAM) && xfer && ((xfer_cnt_q + ONE_L) == total_q);
  assign accum       = ((state_q == STREAM) || (state_q == DRAIN)) && res_valid_i;

  assign op_valid_o  = op_valid_q;
  assign op_data_o   = op_data_q;
  assign busy_o      = (state_q == STREAM) || (state_q == DRAIN);
  assign done_o      = (state_q == DONE);
  assign fill_o      = fill_q;
  assign res_cnt_o   = res_cnt_q;
  assign checksum_o  = checksum_q;

  // State register; reset aborts any run without passing through DONE.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic: streaming ends on the last transfer, draining ends once
  // every transferred beat has produced a result.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_go) state_d = start_ok ? STREAM : DONE;
      STREAM:  if (last_xfer) state_d = DRAIN;
      DRAIN:   if (res_cnt_q == xfer_cnt_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Fill count tracks beats written while idle; clear empties the buffer.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)     fill_q <= '0;
    else if (idle) begin
      if (clear_i)       fill_q <= '0;
      else if (load_acc) fill_q <= fill_q + ONE_L;
    end
  end

  // Beat storage; contents survive reset, only the fill count is cleared.
  always_ff @(posedge clk_i) begin
    if (load_acc) mem[fill_q[AW-1:0]] <= ld_data_i;
  end

  // Streaming datapath: a registered read refills the output register whenever
  // it is empty or being drained, giving one beat per cycle and stable data
  // under backpressure.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      total_q     <= '0;
      fetch_cnt_q <= '0;
      xfer_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      op_valid_q  <= 1'b0;
      op_data_q   <= '0;
    end else if (start_go) begin
      total_q     <= start_ok ? start_total : '0;
      fetch_cnt_q <= '0;
      xfer_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      op_valid_q  <= 1'b0;
    end else begin
      if (fetch) begin
        op_data_q   <= mem[rd_ptr_q];
        op_valid_q  <= 1'b1;
        fetch_cnt_q <= fetch_cnt_q + ONE_L;
        rd_ptr_q    <= ({1'b0, rd_ptr_q} == (fill_q - ONE_L)) ? '0 : rd_ptr_q + 1'b1;
      end else if (xfer) begin
        op_valid_q  <= 1'b0;
      end
      if (xfer) xfer_cnt_q <= xfer_cnt_q + ONE_L;
    end
  end

  // Result accumulation: saturating count and wrapping checksum, held after
  // the run until the next start.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      res_cnt_q  <= '0;
      checksum_q <= '0;
    end else if (start_go) begin
      res_cnt_q  <= '0;
      checksum_q <= '0;
    end else if (accum) begin
      if (res_cnt_q != '1) res_cnt_q <= res_cnt_q + ONE_L;
      checksum_q <= checksum_q + SUM_W'(res_data_i);
    end
  end

endmodule

// File: tb/tb_operand_streamer.sv
// tb_operand_streamer: randomized bench for operand_streamer with a queue-based
// reference model of the buffer, the expected beat order and the result sums.
module tb_operand_streamer;

  localparam int DATA_W  = 8;
  localparam int NUM_OPS = 2;
  localparam int DEPTH   = 8;
  localparam int SUM_W   = 32;
  localparam int AW      = $clog2(DEPTH);
  localparam int BW      = NUM_OPS * DATA_W;

  logic              clk_i = 1'b0;
  logic              reset_ni = 1'b1;
  logic              ld_valid_i = 1'b0;
  logic [BW-1:0]     ld_data_i = '0;
  logic              ld_ready_o;
  logic              clear_i = 1'b0;
  logic              start_i = 1'b0;
  logic [AW:0]       len_i = '0;
  logic              loop_i = 1'b0;
  logic              op_valid_o;
  logic [BW-1:0]     op_data_o;
  logic              op_ready_i = 1'b0;
  logic              res_valid_i = 1'b0;
  logic [DATA_W-1:0] res_data_i = '0;
  logic              busy_o;
  logic              done_o;
  logic [AW:0]       fill_o;
  logic [AW:0]       res_cnt_o;
  logic [SUM_W-1:0]  checksum_o;

  int num_checks = 0;
  int num_errors = 0;

  logic [BW-1:0] m_buf [DEPTH];
  int            m_fill = 0;

  operand_streamer #(
    .DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .DEPTH(DEPTH), .SUM_W(SUM_W)
  ) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .ld_valid_i(ld_valid_i), .ld_data_i(ld_data_i), .ld_ready_o(ld_ready_o),
    .clear_i(clear_i), .start_i(start_i), .len_i(len_i), .loop_i(loop_i),
    .op_valid_o(op_valid_o), .op_data_o(op_data_o), .op_ready_i(op_ready_i),
    .res_valid_i(res_valid_i), .res_data_i(res_data_i),
    .busy_o(busy_o), .done_o(done_o), .fill_o(fill_o),
    .res_cnt_o(res_cnt_o), .checksum_o(checksum_o)
  );

  always #5 clk_i = ~clk_i;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Downstream echo: the result of a beat is the sum of its operands.
  function automatic logic [DATA_W-1:0] beat_sum(input logic [BW-1:0] b);
    logic [DATA_W-1:0] s;
    s = '0;
    for (int k = 0; k < NUM_OPS; k++) s = s + b[k*DATA_W +: DATA_W];
    return s;
  endfunction

  task automatic checkReset(input string pfx);
    checkOutput({pfx, "_ld_ready"}, ld_ready_o, 1);
    checkOutput({pfx, "_op_valid"}, op_valid_o, 0);
    checkOutput({pfx, "_busy"}, busy_o, 0);
    checkOutput({pfx, "_done"}, done_o, 0);
    checkOutput({pfx, "_fill"}, fill_o, 0);
    checkOutput({pfx, "_res_cnt"}, res_cnt_o, 0);
    checkOutput({pfx, "_checksum"}, checksum_o, 0);
  endtask

  // Offer one load beat; the model accepts it only while the buffer has room.
  task automatic loadBeat(input logic [BW-1:0] data);
    @(negedge clk_i);
    clear_i = 1'b0;
    checkOutput("ld_ready", ld_ready_o, (m_fill < DEPTH));
    ld_valid_i = 1'b1;
    ld_data_i  = data;
    if (m_fill < DEPTH) begin
      m_buf[m_fill] = data;
      m_fill++;
    end
  endtask

  task automatic settle();
    @(negedge clk_i);
    ld_valid_i = 1'b0;
    clear_i    = 1'b0;
    checkOutput("fill", fill_o, m_fill);
  endtask

  // Clear with a competing load in the same cycle; the clear must win.
  task automatic clearBuf();
    @(negedge clk_i);
    clear_i    = 1'b1;
    ld_valid_i = 1'b1;
    ld_data_i  = BW'($urandom);
    m_fill     = 0;
    settle();
  endtask

  // One run: start, play downstream with the chosen ready pattern, echo
  // results, and compare beats, timing and the final counters with the model.
  task automatic applyStimulus(input int len, input bit lp, input int mode,
                               input bit with_load, input logic [BW-1:0] load_data);
    logic [BW-1:0]     exp_q [$];
    logic [DATA_W-1:0] res_q [$];
    logic [BW-1:0]     head;
    logic [SUM_W-1:0]  exp_sum;
    int exp_cnt, total, obs, first_valid, last_xfer, done_seen, done_obs;
    bit rdy, valid_seen, finished;
    exp_sum = '0; exp_cnt = 0; total = 0; obs = 0; first_valid = 0;
    last_xfer = 0; done_seen = 0; done_obs = 0; valid_seen = 0; finished = 0;
    @(negedge clk_i);
    start_i    = 1'b1;
    len_i      = (AW+1)'(len);
    loop_i     = lp;
    ld_valid_i = with_load;
    ld_data_i  = load_data;
    op_ready_i = 1'b0;
    res_valid_i = 1'b0;
    if (with_load && m_fill < DEPTH) begin
      m_buf[m_fill] = load_data;
      m_fill++;
    end
    if (len != 0 && m_fill != 0) total = lp ? len : ((len < m_fill) ? len : m_fill);
    for (int i = 0; i < total; i++) exp_q.push_back(m_buf[i % m_fill]);
    while (!finished) begin
      @(negedge clk_i);
      obs++;
      start_i    = 1'b0;
      ld_valid_i = 1'b0;
      if (obs == 1) checkOutput("busy_after_start", busy_o, (total != 0));
      if (done_o) begin
        done_seen++;
        if (done_seen == 1) begin
          done_obs = obs;
          checkOutput("res_cnt_at_done", res_cnt_o, exp_cnt);
          checkOutput("checksum_at_done", checksum_o, exp_sum);
        end
      end
      if (op_valid_o) begin
        if (!valid_seen) first_valid = obs;
        valid_seen = 1;
        if (exp_q.size() == 0) checkOutput("unexpected_beat", op_valid_o, 0);
        else                   checkOutput("op_data", op_data_o, exp_q[0]);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((obs % 4) == 1) || ((obs % 4) == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      op_ready_i = rdy;
      if (res_q.size() > 0 && (mode == 0 || $urandom_range(0, 2) != 0)) begin
        res_valid_i = 1'b1;
        res_data_i  = res_q.pop_front();
        exp_sum     = exp_sum + SUM_W'(res_data_i);
        exp_cnt++;
      end else begin
        res_valid_i = 1'b0;
        res_data_i  = DATA_W'($urandom);
      end
      if (op_valid_o && rdy && exp_q.size() > 0) begin
        head = exp_q.pop_front();
        res_q.push_back(beat_sum(head));
        last_xfer = obs;
      end
      if (done_seen > 0 && obs == done_obs + 2) begin
        checkOutput("done_single_pulse", done_seen, 1);
        checkOutput("res_cnt_held", res_cnt_o, exp_cnt);
        checkOutput("checksum_held", checksum_o, exp_sum);
        checkOutput("idle_not_busy", busy_o, 0);
        finished = 1;
      end
      if (!finished && obs > 600) begin
        checkOutput("run_timeout", done_seen, 1);
        finished = 1;
      end
    end
    op_ready_i  = 1'b0;
    res_valid_i = 1'b0;
    checkOutput("beats_left", exp_q.size(), 0);
    checkOutput("results_left", res_q.size(), 0);
    if (total == 0) begin
      checkOutput("no_valid_direct_done", valid_seen, 0);
      checkOutput("direct_done_latency", done_obs, 1);
    end else begin
      checkOutput("first_valid_latency", first_valid, 2);
      if (mode == 0) checkOutput("back_to_back", last_xfer - first_valid, total - 1);
    end
  endtask

  // Abort a looping run after two transfers and check the asynchronous reset.
  task automatic resetMidStream();
    int xfers, cyc;
    xfers = 0; cyc = 0;
    @(negedge clk_i);
    start_i = 1'b1; len_i = (AW+1)'(15); loop_i = 1'b1; op_ready_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    while (xfers < 2 && cyc < 20) begin
      @(negedge clk_i);
      cyc++;
      if (op_valid_o) xfers++;
    end
    checkOutput("mid_stream_xfers", xfers, 2);
    @(posedge clk_i);
    #2;
    reset_ni = 1'b0;
    #1;
    checkReset("abort");
    @(posedge clk_i);
    #1;
    checkOutput("abort_done_in_reset", done_o, 0);
    @(negedge clk_i);
    reset_ni   = 1'b1;
    op_ready_i = 1'b0;
    m_fill     = 0;
    @(negedge clk_i);
    checkOutput("abort_done_after", done_o, 0);
    checkOutput("abort_fill_after", fill_o, 0);
  endtask

  initial begin
    #1 reset_ni = 1'b0;
    #2 checkReset("por");
    @(negedge clk_i);
    reset_ni = 1'b1;
    settle();

    $display("[TB] directed load and straight run");
    loadBeat(16'h0201);
    loadBeat(16'h0403);
    loadBeat(16'h0605);
    settle();
    applyStimulus(3, 1'b0, 0, 1'b0, '0);
    checkOutput("example_checksum", checksum_o, 32'h15);
    checkOutput("example_res_cnt", res_cnt_o, 3);

    $display("[TB] looping run and stalled run");
    applyStimulus(7, 1'b1, 0, 1'b0, '0);
    checkOutput("loop_res_cnt", res_cnt_o, 7);
    applyStimulus(5, 1'b0, 1, 1'b0, '0);

    $display("[TB] zero length and empty buffer");
    applyStimulus(0, 1'b0, 0, 1'b0, '0);
    clearBuf();
    applyStimulus(4, 1'b0, 0, 1'b0, '0);

    $display("[TB] fill to capacity");
    for (int i = 0; i < DEPTH + 3; i++) loadBeat(BW'($urandom));
    settle();
    checkOutput("full_fill", fill_o, DEPTH);
    applyStimulus(15, 1'b1, 2, 1'b0, '0);

    $display("[TB] start with same-cycle load");
    clearBuf();
    loadBeat(BW'($urandom));
    loadBeat(BW'($urandom));
    settle();
    applyStimulus(5, 1'b0, 0, 1'b1, BW'($urandom));
    checkOutput("start_load_fill", fill_o, 3);

    $display("[TB] randomized runs");
    for (int r = 0; r < 10; r++) begin
      if ($urandom_range(0, 2) == 0) begin
        int n;
        n = $urandom_range(0, DEPTH);
        clearBuf();
        for (int i = 0; i < n; i++) loadBeat(BW'($urandom));
        settle();
      end
      applyStimulus($urandom_range(0, 15), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                    1'($urandom_range(0, 1)), BW'($urandom));
      settle();
    end

    $display("[TB] reset during streaming");
    if (m_fill == 0) begin
      loadBeat(BW'($urandom));
      settle();
    end
    resetMidStream();

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
